// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for param_sync_ram and its read pipeline.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int unsigned RD_LAT_ONE = 1;
  localparam int unsigned RD_LAT_TWO = 2;

  function automatic int unsigned calc_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned calc_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data pipeline: 1 or 2 valid+data register stages; data holds between reads.
module ram_rd_pipe
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STAGES = 1
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [STAGES-1:0] valid_q;
  logic [DATA_W-1:0] data_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      // Later stages only load when the previous stage carries a read.
      for (int unsigned s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) begin
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/param_sync_ram.sv
// Parametrised single-port synchronous RAM with byte enables, request handshake,
// 1/2-cycle read pipeline and a hardware clear sequencer.
module param_sync_ram
  import ram_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     dout,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int unsigned DEPTH = calc_depth(ADDR_W);
  localparam int unsigned LANES = calc_lanes(DATA_W);

  if (RD_LAT != RD_LAT_ONE && RD_LAT != RD_LAT_TWO) begin : g_bad_rd_lat
    $error("param_sync_ram: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("param_sync_ram: DATA_W must be a multiple of 8");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_acc;
  logic                rd_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign wr_acc    = req_valid && req_ready && we;
  assign rd_acc    = req_valid && req_ready && !we;

  // Array has no reset; contents come only from the clear sequencer or writes.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[ptr_q] <= CLEAR_VAL;
    end else if (wr_acc) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (rd_acc),
    .data_i  (mem[addr]),
    .valid_o (rd_valid),
    .data_o  (dout)
  );

endmodule

// File: tb/tb_param_sync_ram.sv
// Directed bench: 8-bit RD_LAT=1 instance and 32-bit RD_LAT=2 instance.
module tb_param_sync_ram;

  logic        clk = 1'b0;
  logic        rst;

  logic        clr8, v8, we8, rdy8, rv8, busy8;
  logic [3:0]  a8;
  logic [7:0]  d8, dout8;
  logic [0:0]  be8;

  logic        clr32, v32, we32, rdy32, rv32, busy32;
  logic [3:0]  a32;
  logic [31:0] d32, dout32;
  logic [3:0]  be32;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_sync_ram #(
    .DATA_W    (8),
    .ADDR_W    (4),
    .RD_LAT    (1),
    .CLEAR_VAL (8'h3C)
  ) dut8 (
    .clk (clk), .rst (rst), .clr (clr8),
    .req_valid (v8), .req_ready (rdy8), .we (we8), .addr (a8),
    .din (d8), .be (be8), .dout (dout8), .rd_valid (rv8), .busy (busy8)
  );

  param_sync_ram #(
    .DATA_W    (32),
    .ADDR_W    (4),
    .RD_LAT    (2),
    .CLEAR_VAL (32'hDEADBEEF)
  ) dut32 (
    .clk (clk), .rst (rst), .clr (clr32),
    .req_valid (v32), .req_ready (rdy32), .we (we32), .addr (a32),
    .din (d32), .be (be32), .dout (dout32), .rd_valid (rv32), .busy (busy32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req8(input logic v, input logic w, input logic [3:0] a,
                      input logic [7:0] d, input logic b);
    v8 = v; we8 = w; a8 = a; d8 = d; be8 = b;
  endtask

  task automatic req32(input logic v, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    v32 = v; we32 = w; a32 = a; d32 = d; be32 = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr8 = 1'b0; clr32 = 1'b0;
    req8(0, 0, 4'h0, 8'h00, 1'b0);
    req32(0, 0, 4'h0, 32'h0, 4'h0);
    tick(); tick();

    chk("rst_busy8",   busy8,  1);
    chk("rst_ready8",  rdy8,   0);
    chk("rst_rv8",     rv8,    0);
    chk("rst_dout8",   dout8,  0);
    chk("rst_busy32",  busy32, 1);
    chk("rst_dout32",  dout32, 0);

    // Power-on clear: busy for exactly 16 cycles after deassert
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("init_busy8",  busy8,  1);
      chk("init_ready8", rdy8,   0);
      chk("init_busy32", busy32, 1);
      tick();
    end
    chk("init_done_busy8",  busy8,  0);
    chk("init_done_ready8", rdy8,   1);
    chk("init_done_busy32", busy32, 0);

    // Every word holds CLEAR_VAL; back-to-back reads
    for (int a = 0; a < 16; a++) begin
      req8(1, 0, 4'(a), 8'h00, 1'b0);
      tick();
      chk("init_rd_rv8",   rv8,   1);
      chk("init_rd_dout8", dout8, 8'h3C);
    end
    req8(0, 0, 4'h0, 8'h00, 1'b0);
    tick();
    chk("init_rd_end_rv8", rv8,   0);
    chk("hold_dout8",      dout8, 8'h3C);

    req32(1, 0, 4'h9, 32'h0, 4'h0);
    tick();
    chk("init_rd32_lat1_rv", rv32, 0);
    req32(0, 0, 4'h0, 32'h0, 4'h0);
    tick();
    chk("init_rd32_rv",   rv32,   1);
    chk("init_rd32_dout", dout32, 32'hDEADBEEF);
    tick();
    chk("init_rd32_end_rv", rv32, 0);

    // Basic write / back-to-back read
    req8(1, 1, 4'h1, 8'hA5, 1'b1);
    tick();
    chk("wr1_rv8", rv8, 0);
    req8(1, 1, 4'h2, 8'h5A, 1'b1);
    tick();
    chk("wr2_rv8", rv8, 0);
    chk("wr2_dout8_held", dout8, 8'h3C);
    req8(1, 0, 4'h1, 8'h00, 1'b0);
    tick();
    chk("rd1_rv8",   rv8,   1);
    chk("rd1_dout8", dout8, 8'hA5);
    req8(1, 0, 4'h2, 8'h00, 1'b0);
    tick();
    chk("rd2_rv8",   rv8,   1);
    chk("rd2_dout8", dout8, 8'h5A);
    req8(0, 0, 4'h0, 8'h00, 1'b0);
    tick();
    chk("rd_end_rv8",   rv8,   0);
    chk("rd_end_dout8", dout8, 8'h5A);

    // Byte enables on 32-bit instance
    req32(1, 1, 4'h3, 32'h11223344, 4'hF);
    tick();
    req32(1, 1, 4'h3, 32'hAABBCCDD, 4'b0101);
    tick();
    chk("be_wr_rv32", rv32, 0);
    req32(1, 0, 4'h3, 32'h0, 4'h0);
    tick();
    chk("be_rd_lat1_rv32", rv32, 0);
    req32(0, 0, 4'h0, 32'h0, 4'h0);
    tick();
    chk("be_rd_rv32",   rv32,   1);
    chk("be_rd_dout32", dout32, 32'h11BB33DD);
    req32(1, 1, 4'h3, 32'hFFFFFFFF, 4'h0);
    tick();
    chk("be0_wr_rv32", rv32, 0);
    req32(1, 0, 4'h3, 32'h0, 4'h0);
    tick();
    req32(0, 0, 4'h0, 32'h0, 4'h0);
    tick();
    chk("be0_rd_rv32",   rv32,   1);
    chk("be0_rd_dout32", dout32, 32'h11BB33DD);

    // Latency 2, write then read next cycle
    req32(1, 1, 4'h7, 32'h00000099, 4'hF);
    tick();
    req32(1, 0, 4'h7, 32'h0, 4'h0);
    tick();
    chk("lat2_acc_rv32",   rv32,   0);
    chk("lat2_acc_dout32", dout32, 32'h11BB33DD);
    req32(0, 0, 4'h0, 32'h0, 4'h0);
    tick();
    chk("lat2_rv32",   rv32,   1);
    chk("lat2_dout32", dout32, 32'h00000099);
    tick();
    chk("lat2_after_rv32",   rv32,   0);
    chk("lat2_after_dout32", dout32, 32'h00000099);

    // Soft clear with a read accepted in the same cycle as clr
    req8(1, 1, 4'h5, 8'hEE, 1'b1);
    tick();
    req8(1, 0, 4'h5, 8'h00, 1'b0);
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("sclr_rd_rv8",   rv8,   1);
    chk("sclr_rd_dout8", dout8, 8'hEE);
    chk("sclr_busy8",    busy8, 1);
    chk("sclr_ready8",   rdy8,  0);
    req8(1, 1, 4'h5, 8'h77, 1'b1);
    for (int i = 0; i < 15; i++) begin
      clr8 = (i == 5);
      tick();
      chk("sclr_run_busy8",  busy8, 1);
      chk("sclr_run_ready8", rdy8,  0);
      chk("sclr_run_rv8",    rv8,   0);
    end
    clr8 = 1'b0;
    tick();
    chk("sclr_done_busy8",  busy8, 0);
    chk("sclr_done_ready8", rdy8,  1);
    req8(1, 0, 4'h5, 8'h00, 1'b0);
    tick();
    chk("sclr_rd5_rv8",   rv8,   1);
    chk("sclr_rd5_dout8", dout8, 8'h3C);
    req8(0, 0, 4'h0, 8'h00, 1'b0);
    tick();

    // Reset in the middle of a clear, with a 32-bit read in flight
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    repeat (5) tick();
    req32(1, 0, 4'h7, 32'h0, 4'h0);
    tick();
    req32(0, 0, 4'h0, 32'h0, 4'h0);
    chk("mid_pre_busy8", busy8, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy8",   busy8,  1);
    chk("mid_rst_ready8",  rdy8,   0);
    chk("mid_rst_rv8",     rv8,    0);
    chk("mid_rst_dout8",   dout8,  0);
    chk("mid_rst_rv32",    rv32,   0);
    chk("mid_rst_dout32",  dout32, 0);
    chk("mid_rst_ready32", rdy32,  0);
    tick(); tick();
    chk("mid_rst_hold_rv32",  rv32,  0);
    chk("mid_rst_hold_busy8", busy8, 1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("re_busy8",  busy8,  1);
      chk("re_busy32", busy32, 1);
      chk("re_rv32",   rv32,   0);
      tick();
    end
    chk("re_done_busy8",  busy8,  0);
    chk("re_done_ready8", rdy8,   1);
    chk("re_done_busy32", busy32, 0);

    req8(1, 0, 4'h1, 8'h00, 1'b0);
    req32(1, 0, 4'h3, 32'h0, 4'h0);
    tick();
    chk("re_rd_rv8",   rv8,   1);
    chk("re_rd_dout8", dout8, 8'h3C);
    chk("re_rd_lat1_rv32", rv32, 0);
    req8(0, 0, 4'h0, 8'h00, 1'b0);
    req32(0, 0, 4'h0, 32'h0, 4'h0);
    tick();
    chk("re_rd_rv32",   rv32,   1);
    chk("re_rd_dout32", dout32, 32'hDEADBEEF);
    chk("re_rd_end_rv8", rv8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
